// File: rtl/armleo_regfile_pkg.sv
// Shared types for the register-file controller slice.
//   ctrl_state_t : controller state (scrub after reset, then normal run)
//   rd_sel_t     : per-read-port source for the data returned one cycle after a read
//   STARVE_CNT_W : width of the wb1 starvation counter (holds STARVE_LIMIT up to 15)
package armleo_regfile_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic {
    ST_SCRUB = 1'b0,
    ST_RUN   = 1'b1
  } ctrl_state_t;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_BYP  = 2'd1,
    SEL_RF   = 2'd2
  } rd_sel_t;

endpackage

// File: rtl/armleo_regfile_bypass.sv
// Read-port forwarding for one register-file read port.
// Remembers, at each accepted read, where the data for the next cycle must come from:
// constant zero (x0), the write data granted in the same cycle (the regfile would
// still return the old value), or the regfile's own synchronous read output.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   read_en             read accepted this cycle (already gated to RUN)
//   addr                read address
//   wr_en/addr/data     write granted this cycle
//   rf_rdata            regfile read data (valid the cycle after a read)
//   rdata               forwarded read data to the pipeline
module armleo_regfile_bypass
  import armleo_regfile_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [WIDTH-1:0]      rf_rdata,
  output logic [WIDTH-1:0]      rdata
);

  rd_sel_t          sel, sel_next;
  logic [WIDTH-1:0] byp_data, byp_data_next;

  // Choose the source for next cycle's data; without a read everything holds.
  always_comb begin
    sel_next      = sel;
    byp_data_next = byp_data;
    if (read_en) begin
      if (addr == '0) begin
        sel_next = SEL_ZERO;
      end else if (wr_en && (wr_addr == addr)) begin
        sel_next      = SEL_BYP;
        byp_data_next = wr_data;
      end else begin
        sel_next = SEL_RF;
      end
    end else begin
      sel_next = sel;
    end
  end

  // Select / captured-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel      <= SEL_ZERO;
      byp_data <= '0;
    end else begin
      sel      <= sel_next;
      byp_data <= byp_data_next;
    end
  end

  // Output mux; forced to zero while reset is held.
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_ZERO: rdata = '0;
      SEL_BYP:  rdata = byp_data;
      SEL_RF:   rdata = rf_rdata;
      default:  rdata = '0;
    endcase
    if (rst) begin
      rdata = '0;
    end else begin
      rdata = rdata;
    end
  end

endmodule

// File: rtl/armleo_regfile_ctrl.sv
// Sequencer/arbiter in front of a 2-read/1-write register file.
// Shares the write port between ALU (wb0) and LSU (wb1) writeback with a starvation
// override for wb1, optionally zero-scrubs registers 1..DEPTH-1 after reset, and
// forwards same-cycle writes to the synchronous read ports.
// Optional feature macro: ARMLEO_REGFILE_CTRL_SCRUB_EN (post-reset scrub; busy meanwhile).
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   ctrl_busy                         scrub in progress (or reset held, with scrub)
//   wb0_valid/ready/addr/wdata        ALU writeback handshake
//   wb1_valid/ready/addr/wdata        LSU writeback handshake
//   rs1_/rs2_ read/addr/rdata         pipeline read ports, data one cycle after read
//   rf_rs1_/rf_rs2_ read/addr/rdata   regfile read ports
//   rf_rd_write/addr/wdata            regfile write port
module armleo_regfile_ctrl
  import armleo_regfile_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH_LOG2   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ctrl_busy,
  input  logic                  wb0_valid,
  output logic                  wb0_ready,
  input  logic [DEPTH_LOG2-1:0] wb0_addr,
  input  logic [WIDTH-1:0]      wb0_wdata,
  input  logic                  wb1_valid,
  output logic                  wb1_ready,
  input  logic [DEPTH_LOG2-1:0] wb1_addr,
  input  logic [WIDTH-1:0]      wb1_wdata,
  input  logic                  rs1_read,
  input  logic [DEPTH_LOG2-1:0] rs1_addr,
  output logic [WIDTH-1:0]      rs1_rdata,
  input  logic                  rs2_read,
  input  logic [DEPTH_LOG2-1:0] rs2_addr,
  output logic [WIDTH-1:0]      rs2_rdata,
  output logic                  rf_rs1_read,
  output logic [DEPTH_LOG2-1:0] rf_rs1_addr,
  input  logic [WIDTH-1:0]      rf_rs1_rdata,
  output logic                  rf_rs2_read,
  output logic [DEPTH_LOG2-1:0] rf_rs2_addr,
  input  logic [WIDTH-1:0]      rf_rs2_rdata,
  output logic                  rf_rd_write,
  output logic [DEPTH_LOG2-1:0] rf_rd_addr,
  output logic [WIDTH-1:0]      rf_rd_wdata
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  logic                    run;
  logic                    scrub_write;
  logic [DEPTH_LOG2-1:0]   scrub_addr;
  logic                    grant0, grant1;
  logic                    wr_en;
  logic [DEPTH_LOG2-1:0]   wr_addr;
  logic [WIDTH-1:0]        wr_data;
  logic [STARVE_CNT_W-1:0] wait_cnt, wait_cnt_next;

`ifdef ARMLEO_REGFILE_CTRL_SCRUB_EN
  ctrl_state_t           state, state_next;
  logic [DEPTH_LOG2-1:0] scrub_addr_next;

  // State and scrub pointer; reset always restarts the scrub at register 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SCRUB;
      scrub_addr <= DEPTH_LOG2'(1);
    end else begin
      state      <= state_next;
      scrub_addr <= scrub_addr_next;
    end
  end

  // Next state: walk the scrub pointer up to the last register, then run.
  always_comb begin
    state_next      = state;
    scrub_addr_next = scrub_addr;
    case (state)
      ST_SCRUB: begin
        scrub_addr_next = scrub_addr + DEPTH_LOG2'(1);
        if (scrub_addr == '1) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_SCRUB;
        end
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_SCRUB;
    endcase
  end

  assign scrub_write = !rst && (state == ST_SCRUB);
  assign run         = !rst && (state == ST_RUN);
  assign ctrl_busy   = rst || (state == ST_SCRUB);
`else
  assign scrub_write = 1'b0;
  assign scrub_addr  = '0;
  assign run         = !rst;
  assign ctrl_busy   = 1'b0;
`endif

  // wb0 has priority unless wb1 has waited STARVE_LIMIT cycles.
  assign grant1    = run && wb1_valid && (!wb0_valid || (wait_cnt >= STARVE_MAX));
  assign grant0    = run && wb0_valid && !grant1;
  assign wb0_ready = grant0;
  assign wb1_ready = grant1;

  // Starvation counter update: count refused wb1 cycles, saturating.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (!wb1_valid || grant1) begin
      wait_cnt_next = '0;
    end else if (wait_cnt < STARVE_MAX) begin
      wait_cnt_next = wait_cnt + STARVE_CNT_W'(1);
    end else begin
      wait_cnt_next = wait_cnt;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt_next;
    end
  end

  // Write-port mux: scrub, else granted writeback. x0 writes are acknowledged but dropped.
  always_comb begin
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    rf_rd_write = 1'b0;
    rf_rd_addr  = '0;
    rf_rd_wdata = '0;
    if (grant1) begin
      wr_en   = 1'b1;
      wr_addr = wb1_addr;
      wr_data = wb1_wdata;
    end else if (grant0) begin
      wr_en   = 1'b1;
      wr_addr = wb0_addr;
      wr_data = wb0_wdata;
    end else begin
      wr_en = 1'b0;
    end
    if (scrub_write) begin
      rf_rd_write = 1'b1;
      rf_rd_addr  = scrub_addr;
    end else if (wr_en) begin
      rf_rd_write = (wr_addr != '0);
      rf_rd_addr  = wr_addr;
      rf_rd_wdata = wr_data;
    end else begin
      rf_rd_write = 1'b0;
    end
  end

  assign rf_rs1_read = run && rs1_read;
  assign rf_rs1_addr = run ? rs1_addr : '0;
  assign rf_rs2_read = run && rs2_read;
  assign rf_rs2_addr = run ? rs2_addr : '0;

  armleo_regfile_bypass #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_byp_rs1 (
    .clk      (clk),
    .rst      (rst),
    .read_en  (rf_rs1_read),
    .addr     (rs1_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rf_rdata (rf_rs1_rdata),
    .rdata    (rs1_rdata)
  );

  armleo_regfile_bypass #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_byp_rs2 (
    .clk      (clk),
    .rst      (rst),
    .read_en  (rf_rs2_read),
    .addr     (rs2_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rf_rdata (rf_rs2_rdata),
    .rdata    (rs2_rdata)
  );

endmodule
